// File: rtl/mips_pkg.sv
// Shared definitions for the hazard unit: divider state encoding,
// forward-select encodings, divider defaults and a register-match helper.
package mips_pkg;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // EX operand select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Default divide latency and counter width (holds 0..64)
    localparam int DIV_CYCLES_DEF = 32;
    localparam int DIV_CNT_W      = 7;

    // Register 0 is hard-wired, so it never creates a dependency
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // MEM result beats WB result because it is the younger producer
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       wr_m,
                                           input logic [4:0] dst_m,
                                           input logic       wr_w,
                                           input logic [4:0] dst_w);
        if (wr_m && reg_match(dst_m, src))
            return FWD_MEM;
        else if (wr_w && reg_match(dst_w, src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle. The pipeline (master) drives the
// register numbers and stage flags; the hazard unit (slave) returns stall,
// flush, forward and divider status. There is no handshake: every output is
// a level that is valid in the same cycle as the inputs that produced it.
interface hazard_ctrl_if;
    import mips_pkg::*;

    logic [4:0]  RsD, RtD;
    logic [4:0]  RsE, RtE, WriteRegE;
    logic [4:0]  WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemtoRegE, MemtoRegM;
    logic        BranchD;
    logic        DivE;

    logic        StallF, StallD, StallE;
    logic        FlushE, FlushM;
    logic        ForwardAD, ForwardBD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        DivBusy, DivDoneE;
    logic [31:0] StallCount;
    div_state_e  DivStateDbg;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, DivE,
        input  StallF, StallD, StallE, FlushE, FlushM, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, DivBusy, DivDoneE, StallCount, DivStateDbg
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, DivE,
        output StallF, StallD, StallE, FlushE, FlushM, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, DivBusy, DivDoneE, StallCount, DivStateDbg
    );

endinterface

// File: rtl/div_seq.sv
// Multi-cycle divide sequencer: IDLE -> BUSY (DIV_CYCLES cycles) -> DONE
// (one cycle) -> IDLE. divstall covers the launch cycle in IDLE and all of
// BUSY; it is forced low while reset is held so an aborted divide releases
// the pipeline without waiting for a clock.
module div_seq
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_div_e,
    output logic       o_divstall,
    output logic       o_div_done,
    output div_state_e o_state
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_CYCLES - 1);

    div_state_e           r_state;
    div_state_e           w_state_nxt;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [DIV_CNT_W-1:0] w_cnt_nxt;

    // State and counter registers with asynchronous abort
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter update and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_divstall  = 1'b0;
        o_div_done  = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (i_div_e) begin
                    w_state_nxt = DIV_BUSY;
                    w_cnt_nxt   = '0;
                    o_divstall  = 1'b1;
                end
            end
            DIV_BUSY: begin
                o_divstall = 1'b1;
                w_cnt_nxt  = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT)
                    w_state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                o_div_done  = 1'b1;
                w_state_nxt = DIV_IDLE;
            end
            default: begin
                w_state_nxt = DIV_IDLE;
            end
        endcase
        if (i_rst) begin
            o_divstall = 1'b0;
            o_div_done = 1'b0;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and
// branch-compare stalls, multi-cycle divide stalls and a saturating count
// of fetch-stall cycles. All control outputs are combinational.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    logic        w_lwstall;
    logic        w_branchstall;
    logic        w_hazstall;
    logic        w_divstall;
    logic        w_div_done;
    logic        w_stall_f;
    div_state_e  w_div_state;
    logic [31:0] r_stall_count;

    div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div_seq (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_div_e    (hz.DivE),
        .o_divstall (w_divstall),
        .o_div_done (w_div_done),
        .o_state    (w_div_state)
    );

    // Forwarding selects for the EX operands and the ID branch comparator
    always_comb begin
        hz.ForwardAE = fwd_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardBE = fwd_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
        hz.ForwardAD = hz.RegWriteM && reg_match(hz.WriteRegM, hz.RsD);
        hz.ForwardBD = hz.RegWriteM && reg_match(hz.WriteRegM, hz.RtD);
    end

    // Load-use and branch-compare hazard detection
    always_comb begin
        w_lwstall     = hz.MemtoRegE &&
                        (reg_match(hz.WriteRegE, hz.RsD) || reg_match(hz.WriteRegE, hz.RtD));
        w_branchstall = hz.BranchD &&
                        ((hz.RegWriteE &&
                          (reg_match(hz.WriteRegE, hz.RsD) || reg_match(hz.WriteRegE, hz.RtD))) ||
                         (hz.MemtoRegM &&
                          (reg_match(hz.WriteRegM, hz.RsD) || reg_match(hz.WriteRegM, hz.RtD))));
        w_hazstall    = w_lwstall || w_branchstall;
    end

    // Stall/flush steering: a divide freezes F/D/E and bubbles MEM,
    // masking the ordinary hazards until it releases
    always_comb begin
        w_stall_f = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushM = 1'b0;
        if (w_divstall) begin
            w_stall_f = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
        end else begin
            w_stall_f = w_hazstall;
            hz.StallD = w_hazstall;
            hz.FlushE = w_hazstall;
        end
    end

    // Saturating count of cycles in which fetch was held
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_count <= '0;
        else if (w_stall_f && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign hz.StallF      = w_stall_f;
    assign hz.DivBusy     = w_divstall;
    assign hz.DivDoneE    = w_div_done;
    assign hz.StallCount  = r_stall_count;
    assign hz.DivStateDbg = w_div_state;

endmodule
